// File: rtl/mul4_seq.sv
// Sequential shift-and-add unsigned multiplier, W x W -> 2W bits, one multiplier bit per clock.
// Latency: W edges from the accepting edge to the one-cycle done pulse; issue interval W+2 cycles.
// Backpressure: none; start is only sampled in IDLE, and a start in RUN or DONE is dropped, not queued.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset (released synchronously by the surrounding design)
//   start    request to begin; sampled only while idle
//   A, B     multiplicand / multiplier, captured on the accepting edge only
//   busy     high while iterating
//   done     one-cycle pulse; P is valid while it is high
//   P        product register, holds the last result until the next operation completes
module mul4_seq #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] P
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [2*W-1:0]   mcand_q;
    logic [W-1:0]     mplier_q;
    logic [2*W-1:0]   acc_q;
    logic [2*W-1:0]   acc_d;
    logic [CW-1:0]    cnt_q;
    logic [2*W-1:0]   p_q;
    logic             busy_q;
    logic             done_q;

    // Partial-product accumulate for the current iteration; the product of two
    // W-bit values always fits in 2W bits, so the add never overflows.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    // busy/done are registered alongside the state so they switch exactly with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mcand_q  <= {{W{1'b0}}, A};
                        mplier_q <= B;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    // Final iteration: publish the completed sum directly from acc_d.
                    if (cnt_q == LAST) begin
                        p_q     <= acc_d;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;

endmodule

// File: tb/tb_mul4_seq.sv
// Self-checking bench for mul4_seq: directed corner cases plus randomized operations
// checked against an arithmetic product model (expected = A * B).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_mul4_seq;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] P;

    int n_tests = 0;
    int n_fail  = 0;

    mul4_seq #(.W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .P       (P)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation with a 1-cycle start. Operands are scrambled right
    // after acceptance to show they are not re-sampled.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input string tag);
        int lat;
        int bcnt;
        int exp_p;
        exp_p = int'(a) * int'(b);
        @(negedge clk);
        start = 1'b1; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        A = 4'($urandom); B = 4'($urandom);
        lat = 0; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, 4);
        chk({tag, " busy_cycles"}, bcnt, 4);
        chk({tag, " P"}, P, exp_p);
        chk({tag, " busy_at_done"}, busy, 0);
        @(negedge clk);
        chk({tag, " done_cleared"}, {busy, done}, 2'b00);
        chk({tag, " P_hold"}, P, exp_p);
    endtask

    initial begin
        int lat;
        int ndone;
        int first_lat;
        int second_lat;
        logic [7:0] first_p;
        logic [7:0] second_p;
        logic       hold_ok;

        reset_n = 1'b1; start = 1'b0; A = '0; B = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset P", P, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Basic example and corner operands
        do_op(4'h7, 4'h5, "7x5");
        do_op(4'hF, 4'hF, "FxF");
        do_op(4'h0, 4'hB, "0xB");
        do_op(4'h9, 4'h1, "9x1");
        do_op(4'h1, 4'h8, "1x8");
        do_op(4'h6, 4'h7, "6x7");

        // Start while busy / done must be ignored
        @(negedge clk);
        start = 1'b1; A = 4'h3; B = 4'h3;
        @(negedge clk);
        start = 1'b0;
        lat = 0; ndone = 0; first_lat = -1;
        while (lat < 14) begin
            if (lat == 1 || (done && ndone == 0)) begin
                start = 1'b1; A = 4'hF; B = 4'hF;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (first_lat < 0) first_lat = lat;
            end
            chk("ignore busy_done_excl", busy & done, 0);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("ignore done_count", ndone, 1);
        chk("ignore latency", first_lat, 4);
        chk("ignore P", P, 8'h09);
        chk("ignore idle", busy, 0);

        // Mid-run reset
        @(negedge clk);
        start = 1'b1; A = 4'h5; B = 4'h5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midrst busy_before", busy, 1);
        reset_n = 1'b0;
        #2;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst P", P, 0);
        #2 reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("midrst no_activity", ndone, 0);
        do_op(4'h2, 4'h3, "postrst 2x3");

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; A = 4'h2; B = 4'h3;
        @(negedge clk);
        A = 4'h4; B = 4'h4;
        lat = 0; ndone = 0; first_lat = -1; second_lat = -1;
        first_p = '0; second_p = '0; hold_ok = 1'b1;
        while (lat < 14) begin
            if (lat == 6) start = 1'b0;
            if (done) begin
                ndone++;
                if (first_lat < 0) begin
                    first_lat = lat; first_p = P;
                end else if (second_lat < 0) begin
                    second_lat = lat; second_p = P;
                end
            end
            if (lat > 4 && lat < 10 && P !== 8'h06) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("b2b done_count", ndone, 2);
        chk("b2b first_lat", first_lat, 4);
        chk("b2b spacing", second_lat - first_lat, 6);
        chk("b2b first_P", first_p, 8'h06);
        chk("b2b second_P", second_p, 8'h10);
        chk("b2b P_hold", hold_ok, 1);

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            do_op(4'($urandom), 4'($urandom), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
